ps2_scancode_ctrl: RTL and testbench

PS2_SCANCODE_CTRL -- requirements
Module: ps2_scancode_ctrl

---
 rtl/ps2_pkg.sv | 15 +
 rtl/ps2_keymap.sv | 19 +
 rtl/ps2_scancode_ctrl.sv | 104 ++++++++++
 tb/tb_ps2_scancode_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared FSM encoding, prefix/discard codes and key map for the PS/2 scan-code controller
package ps2_pkg;
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;
  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] PFX_E1 = 8'hE1;
  localparam logic [7:0] PFX_F0 = 8'hF0;
  localparam logic [5:0][7:0] DISCARD_CODES = {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
  // Entry i is {ext, code} for key index i.
  localparam logic [7:0][8:0] KEY_MAP = {9'h02C, 9'h076, 9'h174, 9'h16B,
                                         9'h172, 9'h175, 9'h05A, 9'h029};
  function automatic logic is_discard(input logic [7:0] code);
    is_discard = 1'b0;
    for (int i = 0; i < 6; i++) if (DISCARD_CODES[i] == code) is_discard = 1'b1;
  endfunction
endpackage

// File: rtl/ps2_keymap.sv
// ps2_keymap: combinational lookup of (code, ext) in the key-map table
module ps2_keymap
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  input  logic       ext,
  output logic       mapped,
  output logic [2:0] index
);
  always_comb begin
    mapped = 1'b0;
    index = 3'd0;
    for (int i = 0; i < 8; i++)
      if (KEY_MAP[i] == {ext, code}) begin
        mapped = 1'b1;
        index = 3'(i);
      end
  end
endmodule

// File: rtl/ps2_scancode_ctrl.sv
// ps2_scancode_ctrl: decodes PS/2 scan-code bytes into make/break key events with held-key tracking
module ps2_scancode_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2_500_000,
  parameter int E1_SKIP_BYTES = 7
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       data_en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_make,
  output logic [2:0] evt_key,
  output logic       evt_mapped,
  output logic [7:0] key_held,
  output logic       overflow
);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] SKIP_INIT = 8'(E1_SKIP_BYTES);
  state_t state, state_nxt;
  logic [31:0] tmo_cnt;
  logic [7:0] skip_cnt;
  logic fire, fire_make, fire_ext, map_hit, emit, hs, tmo_hit;
  logic [2:0] map_idx;
  ps2_keymap u_keymap (
    .code  (received_data),
    .ext   (fire_ext),
    .mapped(map_hit),
    .index (map_idx)
  );
  assign tmo_hit = state != IDLE && tmo_cnt >= TMO_LAST;
  // A make of a key already held is auto-repeat and never becomes an event.
  assign emit = fire && !(fire_make && map_hit && key_held[map_idx]);
  assign hs = evt_valid && evt_ready;
  always_comb begin
    state_nxt = state;
    fire = 1'b0;
    fire_make = 1'b1;
    fire_ext = 1'b0;
    if (data_en) begin
      unique case (state)
        IDLE: begin
          state_nxt = received_data == PFX_F0 ? BRK :
                      received_data == PFX_E0 ? EXT :
                      received_data == PFX_E1 ? SKIP : IDLE;
          fire = state_nxt == IDLE && !is_discard(received_data);
        end
        EXT: begin
          state_nxt = received_data == PFX_F0 ? EXT_BRK : IDLE;
          fire = state_nxt == IDLE;
          fire_ext = 1'b1;
        end
        BRK: begin
          state_nxt = IDLE;
          fire = 1'b1;
          fire_make = 1'b0;
        end
        EXT_BRK: begin
          state_nxt = IDLE;
          fire = 1'b1;
          fire_make = 1'b0;
          fire_ext = 1'b1;
        end
        SKIP: state_nxt = skip_cnt <= 8'd1 ? IDLE : SKIP;
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_hit) state_nxt = IDLE;
  end
  always_ff @(posedge CLOCK_50)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tmo_cnt <= '0;
      skip_cnt <= '0;
      evt_valid <= 1'b0;
      evt_code <= '0;
      evt_ext <= 1'b0;
      evt_make <= 1'b0;
      evt_key <= '0;
      evt_mapped <= 1'b0;
      key_held <= '0;
      overflow <= 1'b0;
    end else begin
      tmo_cnt <= (data_en || state_nxt == IDLE) ? '0 : tmo_cnt + 32'd1;
      skip_cnt <= state_nxt != SKIP ? '0 :
                  state == SKIP ? skip_cnt - {7'd0, data_en} : SKIP_INIT;
      if (fire && map_hit) key_held[map_idx] <= fire_make;
      if (emit && evt_valid && !hs) overflow <= 1'b1;
      else if (emit) begin
        evt_valid <= 1'b1;
        evt_code <= received_data;
        evt_ext <= fire_ext;
        evt_make <= fire_make;
        evt_key <= map_idx;
        evt_mapped <= map_hit;
      end else if (hs) evt_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ps2_scancode_ctrl.sv
// tb_ps2_scancode_ctrl: directed scenarios plus randomized byte streams against a behavioural decoder model
module tb_ps2_scancode_ctrl;
  localparam int TMO = 40;
  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       make;
    logic       mapped;
    logic [2:0] key;
  } ev_t;
  logic clk = 1'b0, reset = 1'b0, data_en = 1'b0, evt_ready = 1'b1;
  logic [7:0] received_data = 8'h00;
  logic evt_valid, evt_ext, evt_make, evt_mapped, overflow;
  logic [7:0] evt_code, key_held;
  logic [2:0] evt_key;
  int checks = 0, errors = 0;
  ev_t obs_q[$], exp_q[$];
  bit m_e0, m_f0;
  int m_skip;
  bit [7:0] m_held;

  ps2_scancode_ctrl #(.TIMEOUT_CYCLES(TMO), .E1_SKIP_BYTES(7)) dut (
    .CLOCK_50(clk), .reset(reset), .received_data(received_data), .data_en(data_en),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_code(evt_code), .evt_ext(evt_ext),
    .evt_make(evt_make), .evt_key(evt_key), .evt_mapped(evt_mapped), .key_held(key_held),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (evt_valid && evt_ready) obs_q.push_back('{evt_code, evt_ext, evt_make, evt_mapped, evt_key});

  function automatic int m_key(input logic [7:0] c, input logic e);
    case ({e, c})
      9'h029: return 0;
      9'h05A: return 1;
      9'h175: return 2;
      9'h172: return 3;
      9'h16B: return 4;
      9'h174: return 5;
      9'h076: return 6;
      9'h02C: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic model_emit(input logic [7:0] c, input bit e, input bit mk);
    int k = m_key(c, e);
    if (mk && k >= 0 && m_held[k]) return;
    exp_q.push_back('{c, e, mk, k >= 0, k >= 0 ? 3'(k) : 3'd0});
    if (k >= 0) m_held[k] = mk;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit idle = !m_e0 && !m_f0;
    if (m_skip > 0) m_skip--;
    else if (idle && b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) ;
    else if (!m_f0 && b == 8'hF0) m_f0 = 1;
    else if (idle && b == 8'hE0) m_e0 = 1;
    else if (idle && b == 8'hE1) m_skip = 7;
    else begin
      model_emit(b, m_e0, !m_f0);
      m_e0 = 0;
      m_f0 = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    received_data = b;
    data_en = 1'b1;
    @(negedge clk);
    data_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    data_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(negedge clk);
    #1;
    obs_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped, key_held, overflow} !== 23'd0) begin
      errors++;
      $display("FAIL reset: valid=%b code=%h ext=%b make=%b key=%0d mapped=%b held=%h ovf=%b required all zero",
               evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped, key_held, overflow);
    end
  endtask

  task automatic test_make_break();
    send_byte(8'h29);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped} !== {1'b1, 8'h29, 1'b0, 1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL make_29: valid=%b code=%h ext=%b make=%b key=%0d mapped=%b required 1 29 0 1 0 1",
               evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped);
    end
    checks++;
    if (key_held[0] !== 1'b1) begin errors++; $display("FAIL held_set: got %b required 1", key_held[0]); end
    send_byte(8'hF0);
    send_byte(8'h29);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped} !== {1'b1, 8'h29, 1'b0, 1'b0, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL break_29: valid=%b code=%h ext=%b make=%b key=%0d mapped=%b required 1 29 0 0 0 1",
               evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped);
    end
    checks++;
    if (key_held[0] !== 1'b0) begin errors++; $display("FAIL held_clr: got %b required 0", key_held[0]); end
  endtask

  task automatic test_typematic();
    settle();
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    repeat (3) @(negedge clk);
    checks++;
    if (obs_q.size() != 2) begin
      errors++;
      $display("FAIL typematic_count: got %0d events required 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== ev_t'{8'h75, 1'b1, 1'b1, 1'b1, 3'd2} || obs_q[1] !== ev_t'{8'h75, 1'b1, 1'b0, 1'b1, 3'd2}) begin
        errors++;
        $display("FAIL typematic_events: got %h %h required %h %h", obs_q[0], obs_q[1],
                 ev_t'{8'h75, 1'b1, 1'b1, 1'b1, 3'd2}, ev_t'{8'h75, 1'b1, 1'b0, 1'b1, 3'd2});
      end
    end
    checks++;
    if (key_held[2] !== 1'b0) begin errors++; $display("FAIL typematic_held: got %b required 0", key_held[2]); end
  endtask

  task automatic test_overflow();
    settle();
    evt_ready = 1'b0;
    send_byte(8'h1C);
    send_byte(8'h1B);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h1C) begin
      errors++;
      $display("FAIL ovf_hold: valid=%b code=%h required 1 1C", evt_valid, evt_code);
    end
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b required 1", overflow); end
    #1 evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b0) begin errors++; $display("FAIL ovf_drain: valid=%b required 0", evt_valid); end
    repeat (5) @(negedge clk);
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    #1 evt_ready = 1'b0;
    send_byte(8'h1C);
    #1;
    received_data = 8'h1B;
    data_en = 1'b1;
    evt_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (evt_valid !== 1'b1 || evt_code !== 8'h1B || overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load: valid=%b code=%h ovf=%b required 1 1B 0", evt_valid, evt_code, overflow);
    end
    #1 data_en = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hE0);
    repeat (10) @(negedge clk);
    send_byte(8'h6B);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_key, evt_mapped} !== {1'b1, 8'h6B, 1'b1, 3'd4, 1'b1}) begin
      errors++;
      $display("FAIL tmo_short: valid=%b code=%h ext=%b key=%0d mapped=%b required 1 6B 1 4 1",
               evt_valid, evt_code, evt_ext, evt_key, evt_mapped);
    end
    send_byte(8'hE0);
    repeat (TMO + 10) @(negedge clk);
    send_byte(8'h29);
    checks++;
    if ({evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped} !== {1'b1, 8'h29, 1'b0, 1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_expired: valid=%b code=%h ext=%b make=%b key=%0d mapped=%b required 1 29 0 1 0 1",
               evt_valid, evt_code, evt_ext, evt_make, evt_key, evt_mapped);
    end
  endtask

  task automatic test_skip();
    int seen = 0;
    do_reset();
    send_byte(8'hE1);
    for (int i = 0; i < 7; i++) begin
      send_byte(8'($urandom_range(0, 255)));
      if (evt_valid) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL skip_quiet: got %0d events required 0", seen); end
    send_byte(8'h5A);
    checks++;
    if ({evt_valid, evt_code, evt_make, evt_key, evt_mapped} !== {1'b1, 8'h5A, 1'b1, 3'd1, 1'b1}) begin
      errors++;
      $display("FAIL skip_after: valid=%b code=%h make=%b key=%0d mapped=%b required 1 5A 1 1 1",
               evt_valid, evt_code, evt_make, evt_key, evt_mapped);
    end
  endtask

  task automatic test_reset_mid();
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h29);
    checks++;
    if ({evt_valid, evt_code, evt_make, evt_ext} !== {1'b1, 8'h29, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: valid=%b code=%h make=%b ext=%b required 1 29 1 0",
               evt_valid, evt_code, evt_make, evt_ext);
    end
  endtask

  task automatic test_random();
    logic [7:0] mapped_codes[8] = '{8'h29, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h76, 8'h2C};
    logic [7:0] disc[6] = '{8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    logic [7:0] b;
    int n;
    do_reset();
    #1 obs_q.delete();
    exp_q.delete();
    m_e0 = 0; m_f0 = 0; m_skip = 0; m_held = '0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1, 2: b = 8'hF0;
        3: b = ($urandom_range(0, 3) == 0) ? 8'hE1 : 8'h1C;
        4, 5, 6: b = mapped_codes[$urandom_range(0, 7)];
        7: b = disc[$urandom_range(0, 5)];
        default: b = 8'($urandom_range(0, 255));
      endcase
      model_byte(b);
      send_byte(b);
      checks++;
      if (key_held !== m_held) begin
        errors++;
        $display("FAIL rand_held[%0d]: byte %h got %h required %h", i, b, key_held, m_held);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rand_count: got %0d events required %0d", obs_q.size(), exp_q.size());
    end
    n = obs_q.size() < exp_q.size() ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rand_event[%0d]: got %h required %h", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_typematic();
    test_overflow();
    test_reset();
    test_back_to_back();
    test_timeout();
    test_skip();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
